dmem_ctrl: RTL

Sequencing controller for the SEQ memory stage against a multi-cycle, handshaked data memory. Accepts one memory-stage operation (icode, valA, valE, valP) per start pulse and decodes it into read, write or no-op. Drives the memory request/ack interface, range-checks the address and applies a response timeout. Returns valM, dmem_error and a one-cycle done strobe; the ready output is the stall source for the SEQ control logic.

---
 rtl/y86_pkg.sv | 23 ++
 rtl/dmem_ctrl_if.sv | 19 +
 rtl/dmem_op_decode.sv | 50 +++++
 rtl/dmem_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86 instruction codes and memory-stage controller state encoding
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'd0;
    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IRRMOVQ = 4'd2;
    localparam logic [3:0] IIRMOVQ = 4'd3;
    localparam logic [3:0] IRMMOVQ = 4'd4;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] ICALL   = 4'd8;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPUSHQ  = 4'd10;
    localparam logic [3:0] IPOPQ   = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - request/ack data memory bus between controller and memory
interface dmem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dmem_op_decode.sv
// rtl/dmem_op_decode.sv - combinational memory-stage decode: direction, address, data, range check
module dmem_op_decode
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic        is_rd,
    output logic        is_wr,
    output logic [63:0] addr,
    output logic [63:0] wdata,
    output logic        addr_err
);

    localparam logic [63:0] LAST_WORD = 64'(MEM_BYTES - 8);

    always_comb begin
        is_rd = 1'b0;
        is_wr = 1'b0;
        addr  = 64'd0;
        wdata = 64'd0;
        case (icode)
            IRMMOVQ, IPUSHQ: begin
                is_wr = 1'b1;
                addr  = valE;
                wdata = valA;
            end
            ICALL: begin
                is_wr = 1'b1;
                addr  = valE;
                wdata = valP;
            end
            IMRMOVQ: begin
                is_rd = 1'b1;
                addr  = valE;
            end
            IRET, IPOPQ: begin
                is_rd = 1'b1;
                addr  = valA;
            end
            default: ;
        endcase
        // Whole word must fit, so the last legal start byte is MEM_BYTES-8
        addr_err = (is_rd | is_wr) && (addr > LAST_WORD);
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - SEQ memory-stage sequencer: decode, request/ack handshake, range and timeout errors
module dmem_ctrl
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int TIMEOUT   = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   icode,
    input  logic [63:0]  valA,
    input  logic [63:0]  valE,
    input  logic [63:0]  valP,
    output logic         ready,
    output logic         done,
    output logic [63:0]  valM,
    output logic         dmem_error,
    dmem_ctrl_if.master  mem
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    dmem_state_t r_state;
    logic        r_done;
    logic [63:0] r_valm;
    logic        r_err;
    logic        r_req;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [CW-1:0] r_cnt;

    logic        w_is_rd;
    logic        w_is_wr;
    logic [63:0] w_addr;
    logic [63:0] w_wdata;
    logic        w_addr_err;

    dmem_op_decode #(.MEM_BYTES(MEM_BYTES)) u_decode (
        .icode    (icode),
        .valA     (valA),
        .valE     (valE),
        .valP     (valP),
        .is_rd    (w_is_rd),
        .is_wr    (w_is_wr),
        .addr     (w_addr),
        .wdata    (w_wdata),
        .addr_err (w_addr_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_valm  <= 64'd0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err <= w_addr_err;
                        if (!(w_is_rd || w_is_wr) || w_addr_err) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                            r_we    <= w_is_wr;
                            r_addr  <= w_addr;
                            r_wdata <= w_wdata;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_REQ: begin
                    // Ack is tested first so a late ack on the timeout edge still succeeds
                    if (mem.mem_ack) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_req   <= 1'b0;
                        if (!r_we) begin
                            r_valm <= mem.mem_rdata;
                        end
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign ready         = (r_state == S_IDLE);
    assign done          = r_done;
    assign valM          = r_valm;
    assign dmem_error    = r_err;
    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;

endmodule
